// File: rtl/pixel_unpacker.sv
// Unpacks 24-bit RGB pixels from a 32-bit AXI-Stream word stream, tags them with
// x/y/SOF/EOL, and checks line/frame framing against tuser/tlast.
module pixel_unpacker #(
  parameter int X_SIZE = 640,
  parameter int Y_SIZE = 480
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [31:0] in_stream_tdata,
  input  logic [3:0]  in_stream_tkeep,
  input  logic        in_stream_tlast,
  input  logic        in_stream_tuser,
  input  logic        in_stream_tvalid,
  output logic        in_stream_tready,
  output logic [7:0]  pix_r,
  output logic [7:0]  pix_g,
  output logic [7:0]  pix_b,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        sof_err,
  output logic        eol_err,
  input  logic        err_clear
);

  localparam int WORDS_PER_LINE = 3 * X_SIZE / 4;
  localparam logic [15:0] LAST_W = 16'(WORDS_PER_LINE - 1);
  localparam logic [9:0]  X_LAST = 10'(X_SIZE - 1);
  localparam logic [8:0]  Y_LAST = 9'(Y_SIZE - 1);

  typedef enum logic {S_HUNT, S_RUN} state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [9:0] x;
    logic [8:0] y;
    logic       sof;
    logic       eol;
  } pix_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_phase;
  logic [15:0] r_widx;
  logic [9:0]  r_x;
  logic [8:0]  r_y;
  logic [15:0] r_res;
  pix_t        r_out, r_pend;
  logic        r_out_valid, r_pend_valid;
  logic        r_sof_err, r_eol_err;
  logic [15:0] r_frame_count;

  logic        w_tready, w_acc, w_start, w_proc, w_sof_hit, w_eol_hit;
  logic        w_last_word, w_line_end, w_two, w_fdone;
  logic [1:0]  w_ph, w_phase_nxt;
  logic [15:0] w_wi, w_widx_nxt, w_res, w_res_nxt;
  logic [9:0]  w_cx, w_x_nxt;
  logic [8:0]  w_cy, w_y_nxt;
  logic [7:0]  w_b0, w_b1, w_b2, w_b3;
  pix_t        w_p0, w_p1;
  logic        w_unused_keep;

  // Every word is treated as full, so tkeep carries no information here.
  assign w_unused_keep = ^in_stream_tkeep;

  assign w_tready = ~areset & ~r_pend_valid & (~r_out_valid | pix_ready);
  assign w_acc    = in_stream_tvalid & w_tready;
  assign w_fdone  = r_out_valid & pix_ready & (r_out.x == X_LAST) & (r_out.y == Y_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_proc      = 1'b0;
    w_sof_hit   = 1'b0;
    case (r_state)
      S_HUNT: begin
        if (w_acc && in_stream_tuser) begin
          w_state_nxt = S_RUN;
          w_start     = 1'b1;
          w_proc      = 1'b1;
        end
      end
      S_RUN: begin
        w_proc    = w_acc;
        w_start   = w_acc & in_stream_tuser;
        w_sof_hit = w_acc & in_stream_tuser & ((r_widx != '0) | (r_y != '0));
      end
      default: w_state_nxt = S_HUNT;
    endcase
  end

  // A frame start (first sync or misplaced tuser) drops residual bytes and zeroes position.
  always_comb begin
    w_ph = w_start ? 2'd0  : r_phase;
    w_wi = w_start ? '0    : r_widx;
    w_cx = w_start ? '0    : r_x;
    w_cy = w_start ? '0    : r_y;
    w_res = w_start ? '0   : r_res;
    {w_b3, w_b2, w_b1, w_b0} = in_stream_tdata;

    w_p0      = '0;
    w_p1      = '0;
    w_two     = 1'b0;
    w_res_nxt = '0;
    case (w_ph)
      2'd0: begin
        {w_p0.r, w_p0.g, w_p0.b} = {w_b0, w_b1, w_b2};
        w_res_nxt = {8'h00, w_b3};
      end
      2'd1: begin
        {w_p0.r, w_p0.g, w_p0.b} = {w_res[7:0], w_b0, w_b1};
        w_res_nxt = {w_b3, w_b2};
      end
      default: begin
        {w_p0.r, w_p0.g, w_p0.b} = {w_res[7:0], w_res[15:8], w_b0};
        {w_p1.r, w_p1.g, w_p1.b} = {w_b1, w_b2, w_b3};
        w_two = 1'b1;
      end
    endcase
    w_p0.x   = w_cx;
    w_p0.y   = w_cy;
    w_p0.sof = (w_cx == '0) && (w_cy == '0);
    w_p0.eol = (w_cx == X_LAST);
    w_p1.x   = w_cx + 10'd1;
    w_p1.y   = w_cy;
    w_p1.sof = 1'b0;
    w_p1.eol = ((w_cx + 10'd1) == X_LAST);

    // The word counter is authoritative: the line ends at the last word even without tlast.
    w_last_word = (w_wi == LAST_W);
    w_line_end  = w_last_word | in_stream_tlast;
    w_eol_hit   = w_proc & (in_stream_tlast ^ w_last_word);

    if (w_line_end) begin
      w_widx_nxt  = '0;
      w_phase_nxt = 2'd0;
      w_x_nxt     = '0;
      w_y_nxt     = (w_cy == Y_LAST) ? 9'd0 : w_cy + 9'd1;
      w_res_nxt   = '0;
    end else begin
      w_widx_nxt  = w_wi + 16'd1;
      w_phase_nxt = (w_ph == 2'd2) ? 2'd0 : w_ph + 2'd1;
      w_x_nxt     = w_cx + (w_two ? 10'd2 : 10'd1);
      w_y_nxt     = w_cy;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state       <= S_HUNT;
      r_phase       <= '0;
      r_widx        <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_res         <= '0;
      r_out         <= '0;
      r_pend        <= '0;
      r_out_valid   <= 1'b0;
      r_pend_valid  <= 1'b0;
      r_sof_err     <= 1'b0;
      r_eol_err     <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_proc) begin
        r_phase      <= w_phase_nxt;
        r_widx       <= w_widx_nxt;
        r_x          <= w_x_nxt;
        r_y          <= w_y_nxt;
        r_res        <= w_res_nxt;
        r_out        <= w_p0;
        r_out_valid  <= 1'b1;
        r_pend       <= w_p1;
        r_pend_valid <= w_two;
      end else if (r_out_valid && pix_ready) begin
        if (r_pend_valid) begin
          r_out        <= r_pend;
          r_pend_valid <= 1'b0;
        end else begin
          r_out_valid  <= 1'b0;
        end
      end
      r_sof_err <= (r_sof_err & ~err_clear) | w_sof_hit;
      r_eol_err <= (r_eol_err & ~err_clear) | w_eol_hit;
      if (w_fdone) r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign in_stream_tready = w_tready;
  assign pix_r       = r_out.r;
  assign pix_g       = r_out.g;
  assign pix_b       = r_out.b;
  assign pix_x       = r_out.x;
  assign pix_y       = r_out.y;
  assign pix_sof     = r_out.sof;
  assign pix_eol     = r_out.eol;
  assign pix_valid   = r_out_valid;
  assign frame_done  = w_fdone;
  assign frame_count = r_frame_count;
  assign sof_err     = r_sof_err;
  assign eol_err     = r_eol_err;

endmodule

// File: doc/pixel_unpacker.md
Name: pixel_unpacker

Overview:
- Receive side of the packed video stream produced by the pixel packer: an AXI-Stream slave that takes 32-bit words carrying tightly packed 24-bit RGB pixels and emits one pixel per handshake, tagged with x/y, SOF and EOL.
- Checks frame geometry against SOF (tuser) and EOL (tlast), resynchronises on errors and reports sticky error flags and a frame counter.
- Sits in front of on-chip consumers such as a frame checker or a loopback test path.

Parameters:
- X_SIZE, 640, pixels per line; must be a multiple of 4.
- Y_SIZE, 480, lines per frame.
- WORDS_PER_LINE, 3*X_SIZE/4 (localparam), stream words per line.

Ports:
- aclk  in  1  single clock for all logic.
- areset  in  1  asynchronous, active-high reset.
- in_stream_tdata  in  32  packed pixel bytes.
- in_stream_tkeep  in  4  ignored; every word is treated as full.
- in_stream_tlast  in  1  last word of a line.
- in_stream_tuser  in  1  first word of a frame.
- in_stream_tvalid  in  1  word valid.
- in_stream_tready  out  1  word accepted when tvalid & tready.
- pix_r, pix_g, pix_b  out  8 each  pixel colour.
- pix_x  out  10  pixel column.
- pix_y  out  9  pixel row.
- pix_sof  out  1  pixel (0,0).
- pix_eol  out  1  pixel x==X_SIZE-1.
- pix_valid  out  1  pixel valid.
- pix_ready  in  1  consumer accepts when pix_valid & pix_ready.
- frame_done  out  1  one-cycle pulse when pixel (X_SIZE-1, Y_SIZE-1) handshakes.
- frame_count  out  16  completed frames; wraps at 0xFFFF->0.
- sof_err  out  1  sticky; tuser seen at an unexpected position.
- eol_err  out  1  sticky; tlast missing or early.
- err_clear  in  1  synchronous clear of both sticky flags. A new error in the same cycle wins.

Behaviour:
- Byte order:
  - Stream byte k = word k/4, bits [8*(k%4)+:8].
  - Pixel n = bytes 3n (R), 3n+1 (G), 3n+2 (B).
  - Each line starts byte-aligned at word 0.
- Phase counter 0,1,2 (residual bytes 0,1,2), cycled per accepted word:
  - Phase 0 word emits 1 pixel and keeps 1 byte.
  - Phase 1 word emits 1 pixel and keeps 2 bytes.
  - Phase 2 word emits 2 pixels and keeps 0 bytes.
- Output stage: output register plus one pending register.
  - in_stream_tready = synced_or_hunting & !pend_valid & (!pix_valid | pix_ready).
  - On a phase-2 accept, the first pixel goes to the output register and the second to pending.
  - Pending moves to the output register on the next pix_ready.
  - Sustained rate is 1 pixel/cycle.
- Latency: a word accepted at cycle t gives its first pixel on pix_valid at t+1.
- pix_* fields stay stable while pix_valid & !pix_ready.
- FSM states HUNT and RUN:
  - HUNT (reset state): tready=1; words are accepted and discarded until a word with tuser=1 arrives. That word is processed as word 0 of line 0 and the FSM enters RUN.
  - RUN: the word index (0..WORDS_PER_LINE-1), phase and x/y advance per accepted word/pixel.
- SOF check in RUN:
  - A tuser=1 word not at (word 0, line 0) sets sof_err.
  - Residual bytes are dropped; word index, phase, x and y are reset to 0; the word is processed as a frame start.
  - Pixels already in the output or pending registers are still delivered.
- EOL checks:
  - tlast on word index < WORDS_PER_LINE-1 sets eol_err. Residual bytes are dropped, x=0, y advances (wraps at Y_SIZE), and the next word is word 0.
  - Word index WORDS_PER_LINE-1 without tlast sets eol_err; the line ends anyway (position counter is authoritative).
- y wraps from Y_SIZE-1 to 0.
  - On wrap without a following tuser, the next word is still treated as frame start; sof_err is set only if tuser is present at the wrong place, not if absent.
- pix_sof = (x==0 & y==0); pix_eol = (x==X_SIZE-1).
- Reset values:
  - in_stream_tready=0 while areset is high, and 1 on the first cycle after release (HUNT).
  - pix_valid=0, all pix fields 0, frame_done=0, frame_count=0, sof_err=0, eol_err=0.
  - FSM=HUNT, phase=0, pend_valid=0.
- Reset asserted mid-frame: everything returns to reset values immediately; the first post-reset frame requires tuser.

Test Plan:
- Stream geometry for all scenarios: X_SIZE=8, Y_SIZE=2 (6 words/line).
- Word 0x03020100 with tuser, then 0x07060504, 0x0B0A0908 -> pixels (R,G,B) = (00,01,02), (03,04,05), (06,07,08), (09,0A,0B) at x=0..3, y=0; the first has pix_sof=1.
- Full frame with pix_ready=1 and tvalid=1 -> 16 pixels in 16 consecutive cycles after first latency. The last pixel has pix_eol=1, x=7, y=1. frame_done pulses once; frame_count=1; no errors.
- pix_ready toggling 1/0 -> no pixel lost or duplicated, and outputs stay stable during stall. The phase-2 word stalls tready exactly one cycle with ready high.
- 3 words without tuser after reset -> discarded, no pix_valid. Then a tuser word -> pixel (0,0) with pix_sof.
- tlast on word index 2 -> eol_err=1, residual dropped. The next word yields x=0, y=1. err_clear -> eol_err=0.
- tuser on word 4 of line 0 -> sof_err=1, and the next pixel is emitted at x=0, y=0 with pix_sof. Assert areset mid-line -> all outputs at reset values within the same cycle.
